cntr_seq_checker: RTL and testbench

//  Receive-side checker for a wrapping modulo counter stream (0,1,..,MAX,0,..), the

---
 rtl/cntr_seq_pkg.sv | 10 +
 rtl/cntr_seq_sat_cnt.sv | 16 +
 rtl/cntr_seq_checker.sv | 113 +++++++++++
 tb/tb_cntr_seq_checker.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cntr_seq_pkg.sv
// Shared types for the modulo counter sequence checker.
package cntr_seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } cntr_seq_state_t;

endpackage

// File: rtl/cntr_seq_sat_cnt.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module cntr_seq_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    count <= '0;
    else if (inc && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/cntr_seq_checker.sv
// Receive-side checker for a wrapping 0..MAX counter stream: hunts, locks,
// predicts the next value and flags deviations while locked.
module cntr_seq_checker
  import cntr_seq_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MAX      = 2,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_cntr,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             err,
  output logic             out_of_range,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
    return (v == MAX_V) ? '0 : v + 1'b1;
  endfunction

  cntr_seq_state_t state;
  logic [GW-1:0]   good;
  logic [BW-1:0]   bad;

  logic          oor, match, err_fire;
  logic [GW-1:0] good_inc;
  logic [BW-1:0] bad_inc;

  // expected never exceeds MAX, so an out-of-range sample is always a mismatch
  assign oor      = in_cntr > MAX_V;
  assign match    = in_cntr == expected;
  assign err_fire = in_valid && state == LOCKED && !match;
  assign good_inc = good + 1'b1;
  assign bad_inc  = bad + 1'b1;
  assign locked   = state == LOCKED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      expected     <= '0;
      good         <= '0;
      bad          <= '0;
      err          <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      err          <= err_fire;
      out_of_range <= in_valid && oor;
      if (in_valid) begin
        case (state)
          HUNT: if (!oor) begin
            expected <= nxt(in_cntr);
            good     <= GW'(1);
            state    <= (LOCK_CNT == 1) ? LOCKED : SYNC;
          end
          SYNC: if (oor) begin
            state <= HUNT;
            good  <= '0;
          end else if (match) begin
            expected <= nxt(in_cntr);
            good     <= good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state <= LOCKED;
              bad   <= '0;
            end
          end else begin
            expected <= nxt(in_cntr);
            good     <= GW'(1);
          end
          LOCKED: if (match) begin
            expected <= nxt(expected);
            bad      <= '0;
          end else if (bad_inc == BW'(LOSS_CNT)) begin
            state    <= HUNT;
            expected <= '0;
            good     <= '0;
            bad      <= '0;
          end else begin
            // flywheel: keep predicting through isolated glitches
            expected <= nxt(expected);
            bad      <= bad_inc;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  cntr_seq_sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_fire),
    .count (err_count)
  );

`ifdef FORMAL
  a_exp_range:  assert property (@(posedge clk) disable iff (reset) expected <= MAX_V);
  a_locked:     assert property (@(posedge clk) disable iff (reset) locked == (state == LOCKED));
  a_err_locked: assert property (@(posedge clk) disable iff (reset) err |-> $past(locked));
  a_cnt_mono:   assert property (@(posedge clk) disable iff (reset)
                                 !$past(reset) |-> err_count >= $past(err_count));
`endif

endmodule

// File: tb/tb_cntr_seq_checker.sv
// Directed bench for cntr_seq_checker: defaults instance plus a small-ERR_W instance.
module tb_cntr_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_cntr = '0;

  logic       locked, err, out_of_range;
  logic [1:0] expected;
  logic [7:0] err_count;

  logic       locked2, err2, oor2;
  logic [1:0] expected2;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cntr_seq_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_cntr(in_cntr),
    .locked(locked), .expected(expected), .err(err),
    .out_of_range(out_of_range), .err_count(err_count)
  );

  cntr_seq_checker #(.ERR_W(2), .LOSS_CNT(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_cntr(in_cntr),
    .locked(locked2), .expected(expected2), .err(err2),
    .out_of_range(oor2), .err_count(err_count2)
  );

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  // one sample per call, outputs observed 1 time unit after the consuming edge
  task automatic sample(input logic [1:0] v);
    @(negedge clk); in_valid = 1'b1; in_cntr = v;
    @(posedge clk); #1; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL rst_locked got %0d want 0", locked); end
    checks++; if (expected !== 2'd0)  begin errors++; $display("FAIL rst_expected got %0d want 0", expected); end
    checks++; if (err !== 1'b0 || out_of_range !== 1'b0)
      begin errors++; $display("FAIL rst_pulses got err=%0d oor=%0d want 0 0", err, out_of_range); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_lock();
    do_reset();
    sample(2'd0);
    checks++; if (expected !== 2'd1 || locked !== 1'b0)
      begin errors++; $display("FAIL lock_after0 got exp=%0d lk=%0d want 1 0", expected, locked); end
    sample(2'd1);
    checks++; if (locked !== 1'b1 || expected !== 2'd2)
      begin errors++; $display("FAIL lock_after1 got lk=%0d exp=%0d want 1 2", locked, expected); end
    sample(2'd2);
    sample(2'd0);
    checks++; if (expected !== 2'd1 || err !== 1'b0 || locked !== 1'b1)
      begin errors++; $display("FAIL lock_wrap got exp=%0d err=%0d lk=%0d want 1 0 1", expected, err, locked); end
  endtask

  task automatic test_flywheel();
    do_reset();
    sample(2'd0); sample(2'd1);
    sample(2'd0);
    checks++; if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b1)
      begin errors++; $display("FAIL fly_miss got err=%0d cnt=%0d lk=%0d want 1 1 1", err, err_count, locked); end
    sample(2'd0);
    checks++; if (err !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1 || expected !== 2'd1)
      begin errors++; $display("FAIL fly_recover got err=%0d cnt=%0d lk=%0d exp=%0d want 0 1 1 1", err, err_count, locked, expected); end
  endtask

  task automatic test_loss();
    do_reset();
    sample(2'd0); sample(2'd1);
    sample(2'd1);
    checks++; if (err !== 1'b1 || locked !== 1'b1)
      begin errors++; $display("FAIL loss_first got err=%0d lk=%0d want 1 1", err, locked); end
    sample(2'd1);
    checks++; if (err !== 1'b1 || err_count !== 8'd2 || locked !== 1'b0 || expected !== 2'd0)
      begin errors++; $display("FAIL loss_second got err=%0d cnt=%0d lk=%0d exp=%0d want 1 2 0 0", err, err_count, locked, expected); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    sample(2'd3);
    checks++; if (out_of_range !== 1'b1 || err !== 1'b0 || locked !== 1'b0)
      begin errors++; $display("FAIL oor_hunt got oor=%0d err=%0d lk=%0d want 1 0 0", out_of_range, err, locked); end
    sample(2'd0); sample(2'd1);
    sample(2'd3);
    checks++; if (out_of_range !== 1'b1 || err !== 1'b1 || err_count !== 8'd1)
      begin errors++; $display("FAIL oor_locked got oor=%0d err=%0d cnt=%0d want 1 1 1", out_of_range, err, err_count); end
    @(posedge clk); #1;
    checks++; if (out_of_range !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL oor_idle got oor=%0d err=%0d want 0 0", out_of_range, err); end
  endtask

  task automatic test_saturate();
    logic [1:0] seq  [10] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
    logic [1:0] cnts [5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    sample(2'd0); sample(2'd1);
    for (int i = 0; i < 10; i++) begin
      sample(seq[i]);
      if (i % 2 == 0) begin
        checks++; if (err2 !== 1'b1 || err_count2 !== cnts[i/2])
          begin errors++; $display("FAIL sat_miss%0d got err=%0d cnt=%0d want 1 %0d", i/2, err2, err_count2, cnts[i/2]); end
      end
    end
    checks++; if (locked2 !== 1'b1 || expected2 !== 2'd0)
      begin errors++; $display("FAIL sat_end got lk=%0d exp=%0d want 1 0", locked2, expected2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sample(2'd0); sample(2'd1); sample(2'd0);
    @(negedge clk); in_valid = 1'b1; in_cntr = 2'd2; reset = 1'b1;
    #1;
    checks++; if (locked !== 1'b0 || expected !== 2'd0 || err_count !== 8'd0 || err !== 1'b0)
      begin errors++; $display("FAIL mid_reset got lk=%0d exp=%0d cnt=%0d err=%0d want 0 0 0 0", locked, expected, err_count, err); end
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    sample(2'd2);
    checks++; if (locked !== 1'b0 || expected !== 2'd0)
      begin errors++; $display("FAIL mid_relock1 got lk=%0d exp=%0d want 0 0", locked, expected); end
    sample(2'd0);
    checks++; if (locked !== 1'b1 || expected !== 2'd1)
      begin errors++; $display("FAIL mid_relock2 got lk=%0d exp=%0d want 1 1", locked, expected); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_flywheel();
    test_loss();
    test_out_of_range();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
